// File: rtl/riscv_pkg.sv
// Shared types for the operand forwarding controller.
package riscv_pkg;

  localparam int unsigned REG_AW  = 5;
  localparam int unsigned NUM_STG = 4;

  // ALU operand mux select; youngest producer has the smallest code after RF
  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10,
    FWD_RET   = 2'b11
  } fwd_sel_t;

  // One shadow pipeline entry tracking an in-flight destination register
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
  } shadow_stg_t;

  typedef enum logic [1:0] {
    FC_RUN      = 2'b00,
    FC_LU_STALL = 2'b01,
    FC_MEM_WAIT = 2'b10
  } fc_state_t;

  // A stage supplies rs when it writes that register and rs is not x0
  function automatic logic rd_hit(input logic wr, input logic [REG_AW-1:0] rd,
                                  input logic [REG_AW-1:0] rs);
    return wr && (rd == rs) && (rs != '0);
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Priority compare of one source register against the three producer stages.
// wr[0]/rd_ex is the youngest (becomes EX/MEM), wr[2]/rd_wb the oldest (becomes RET).
module fwd_match
  import riscv_pkg::*;
(
  input  logic [REG_AW-1:0]  rs,
  input  logic [NUM_STG-2:0] wr,
  input  logic [REG_AW-1:0]  rd_ex,
  input  logic [REG_AW-1:0]  rd_mem,
  input  logic [REG_AW-1:0]  rd_wb,
  output fwd_sel_t           sel
);

  // Later assignments override earlier ones, so the youngest match wins
  always_comb begin
    sel = FWD_RF;
    if (rd_hit(wr[2], rd_wb, rs))  sel = FWD_RET;
    if (rd_hit(wr[1], rd_mem, rs)) sel = FWD_MEMWB;
    if (rd_hit(wr[0], rd_ex, rs))  sel = FWD_EXMEM;
  end

endmodule

// File: rtl/operand_forward_ctrl.sv
// Forwarding selector generation, load-use stall and memory-wait hold for the EX operand muxes.
// The RET stage needs no storage: its selector is decided while the producer still sits in WB.
module operand_forward_ctrl
  import riscv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              flush,
  input  logic              dmem_ready,
  output fwd_sel_t          ex_fwd_sel_a,
  output fwd_sel_t          ex_fwd_sel_b,
  output logic              stall_if_id,
  output logic              bubble_ex,
  output logic              pipe_hold
);

  fc_state_t          state, state_nxt;
  shadow_stg_t        ex_stg, mem_stg, ex_in;
  logic               wb_wr;
  logic [REG_AW-1:0]  wb_rd;
  logic [NUM_STG-2:0] stg_wr;
  fwd_sel_t           sel_a_c, sel_b_c, sel_a_in, sel_b_in;
  logic               shift, load_use, mem_wait;

  assign load_use = ex_stg.valid && ex_stg.mem_read && (ex_stg.rd != '0) && id_valid &&
                    ((ex_stg.rd == id_rs1) || (ex_stg.rd == id_rs2));
  assign mem_wait = mem_stg.valid && mem_stg.mem_read && !dmem_ready;
  assign stg_wr   = {wb_wr, mem_stg.valid & mem_stg.reg_write, ex_stg.valid & ex_stg.reg_write};

  fwd_match u_match_a (
    .rs     (id_rs1),
    .wr     (stg_wr),
    .rd_ex  (ex_stg.rd),
    .rd_mem (mem_stg.rd),
    .rd_wb  (wb_rd),
    .sel    (sel_a_c)
  );

  fwd_match u_match_b (
    .rs     (id_rs2),
    .wr     (stg_wr),
    .rd_ex  (ex_stg.rd),
    .rd_mem (mem_stg.rd),
    .rd_wb  (wb_rd),
    .sel    (sel_b_c)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FC_RUN;
    else     state <= state_nxt;
  end

  // Next state, state-decoded controls and the value loaded into the EX shadow.
  // A load-use hazard shifts a bubble into EX at the detect edge, so during the
  // stall cycle the held ID instruction sees the load in MEM and forwards 10.
  always_comb begin
    state_nxt   = state;
    stall_if_id = 1'b0;
    bubble_ex   = 1'b0;
    pipe_hold   = 1'b0;
    shift       = 1'b0;
    ex_in       = '0;
    sel_a_in    = FWD_RF;
    sel_b_in    = FWD_RF;
    case (state)
      FC_RUN: begin
        if (mem_wait) begin
          state_nxt = FC_MEM_WAIT;
        end else begin
          shift = 1'b1;
          if (!flush && load_use) state_nxt = FC_LU_STALL;
        end
      end
      FC_LU_STALL: begin
        stall_if_id = 1'b1;
        bubble_ex   = 1'b1;
        if (mem_wait) begin
          state_nxt = FC_MEM_WAIT;
        end else begin
          shift     = 1'b1;
          state_nxt = FC_RUN;
        end
      end
      FC_MEM_WAIT: begin
        pipe_hold = 1'b1;
        if (dmem_ready) state_nxt = FC_RUN;
      end
      default: state_nxt = FC_RUN;
    endcase
    if (shift && id_valid && !flush && !((state == FC_RUN) && load_use)) begin
      ex_in    = '{valid: 1'b1, rd: id_rd, reg_write: id_reg_write, mem_read: id_mem_read};
      sel_a_in = sel_a_c;
      sel_b_in = sel_b_c;
    end
  end

  // Shadow pipeline and registered selectors; everything holds when not shifting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_stg       <= '0;
      mem_stg      <= '0;
      wb_wr        <= 1'b0;
      wb_rd        <= '0;
      ex_fwd_sel_a <= FWD_RF;
      ex_fwd_sel_b <= FWD_RF;
    end else if (shift) begin
      ex_stg       <= ex_in;
      mem_stg      <= ex_stg;
      wb_wr        <= mem_stg.valid & mem_stg.reg_write;
      wb_rd        <= mem_stg.rd;
      ex_fwd_sel_a <= sel_a_in;
      ex_fwd_sel_b <= sel_b_in;
    end
  end

endmodule

// File: tb/tb_operand_forward_ctrl.sv
// Directed bench for operand_forward_ctrl with hand-computed expectations.
module tb_operand_forward_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_reg_write, id_mem_read;
  logic       flush, dmem_ready;
  logic [1:0] sel_a, sel_b;
  logic       stall, bubble, hold;

  int n_assert = 0;
  int n_fail   = 0;

  operand_forward_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .flush        (flush),
    .dmem_ready   (dmem_ready),
    .ex_fwd_sel_a (sel_a),
    .ex_fwd_sel_b (sel_b),
    .stall_if_id  (stall),
    .bubble_ex    (bubble),
    .pipe_hold    (hold)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input int rs1, input int rs2, input int rd,
                        input logic rw, input logic mr);
    id_valid     = v;
    id_rs1       = 5'(rs1);
    id_rs2       = 5'(rs2);
    id_rd        = 5'(rd);
    id_reg_write = rw;
    id_mem_read  = mr;
  endtask

  // Present one instruction in ID for one clock
  task automatic issue(input int rs1, input int rs2, input int rd, input logic mr);
    set_id(1'b1, rs1, rs2, rd, 1'b1, mr);
    tick();
  endtask

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst        = 1'b1;
    flush      = 1'b0;
    dmem_ready = 1'b1;
    set_id(1'b0, 0, 0, 0, 1'b0, 1'b0);
    tick();
    tick();
    chk("rst_sel_a", sel_a, 2'd0);
    chk("rst_sel_b", sel_b, 2'd0);
    chk("rst_stall", {1'b0, stall}, 2'd0);
    chk("rst_bubble", {1'b0, bubble}, 2'd0);
    chk("rst_hold", {1'b0, hold}, 2'd0);
    rst = 1'b0;

    // back-to-back ALU: add x5 ; sub x8,x5,x6
    issue(0, 0, 5, 1'b0);
    chk("b2b_prod_sel_a", sel_a, 2'd0);
    issue(5, 6, 8, 1'b0);
    chk("b2b_sel_a", sel_a, 2'd1);
    chk("b2b_sel_b", sel_b, 2'd0);
    chk("b2b_stall", {1'b0, stall}, 2'd0);

    // distance 2: x7 producer, one unrelated, consumer
    issue(0, 0, 7, 1'b0);
    issue(1, 2, 10, 1'b0);
    issue(7, 0, 11, 1'b0);
    chk("dist2_sel_a", sel_a, 2'd2);
    chk("dist2_sel_b", sel_b, 2'd0);

    // distance 3: x12 producer, two unrelated, consumer on rs2
    issue(0, 0, 12, 1'b0);
    issue(0, 0, 13, 1'b0);
    issue(0, 0, 14, 1'b0);
    issue(0, 12, 15, 1'b0);
    chk("dist3_sel_b", sel_b, 2'd3);
    chk("dist3_sel_a", sel_a, 2'd0);

    // load-use: lw x3 ; add x4,x3,x3
    issue(0, 0, 3, 1'b1);
    set_id(1'b1, 3, 3, 4, 1'b1, 1'b0);
    tick();
    chk("lu_stall", {1'b0, stall}, 2'd1);
    chk("lu_bubble", {1'b0, bubble}, 2'd1);
    chk("lu_bubble_sel_a", sel_a, 2'd0);
    tick();
    chk("lu_after_stall", {1'b0, stall}, 2'd0);
    chk("lu_after_bubble", {1'b0, bubble}, 2'd0);
    chk("lu_sel_a", sel_a, 2'd2);
    chk("lu_sel_b", sel_b, 2'd2);

    // x0 producers never forward
    issue(0, 0, 0, 1'b0);
    issue(0, 0, 0, 1'b0);
    issue(0, 0, 16, 1'b0);
    chk("x0_sel_a", sel_a, 2'd0);
    chk("x0_sel_b", sel_b, 2'd0);
    // a load to x0 is not a load-use hazard
    issue(0, 0, 0, 1'b1);
    issue(0, 0, 18, 1'b0);
    chk("x0_load_no_stall", {1'b0, stall}, 2'd0);

    // x9 written at distance 1 and 2: youngest wins
    issue(0, 0, 9, 1'b0);
    issue(0, 0, 9, 1'b0);
    issue(9, 9, 17, 1'b0);
    chk("prio_sel_a", sel_a, 2'd1);
    chk("prio_sel_b", sel_b, 2'd1);
    // x20 at distance 2 and 3: WB beats RET
    issue(0, 0, 20, 1'b0);
    issue(0, 0, 20, 1'b0);
    issue(0, 0, 19, 1'b0);
    issue(20, 0, 28, 1'b0);
    chk("prio_wb_over_ret", sel_a, 2'd2);

    // flush coincident with load-use: no stall, discarded ID never forwards
    issue(0, 0, 3, 1'b1);
    set_id(1'b1, 3, 0, 21, 1'b1, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_stall", {1'b0, stall}, 2'd0);
    chk("flush_bubble", {1'b0, bubble}, 2'd0);
    chk("flush_sel_a", sel_a, 2'd0);
    issue(21, 3, 30, 1'b0);
    chk("flush_killed_sel_a", sel_a, 2'd0);
    chk("flush_load_sel_b", sel_b, 2'd2);
    chk("flush_next_stall", {1'b0, stall}, 2'd0);

    // memory wait: add x25 ; lw x22,(x25) ; add x23,x25,x25 ; then x24 = x22 op x23
    issue(0, 0, 25, 1'b0);
    issue(25, 0, 22, 1'b1);
    issue(25, 25, 23, 1'b0);
    chk("mw_pre_sel_b", sel_b, 2'd2);
    set_id(1'b1, 22, 23, 24, 1'b1, 1'b0);
    dmem_ready = 1'b0;
    tick();
    chk("mw_hold_1", {1'b0, hold}, 2'd1);
    chk("mw_sel_a_1", sel_a, 2'd2);
    chk("mw_sel_b_1", sel_b, 2'd2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("mw_hold_2", {1'b0, hold}, 2'd1);
    chk("mw_flush_ignored_sel_b", sel_b, 2'd2);
    tick();
    chk("mw_hold_3", {1'b0, hold}, 2'd1);
    dmem_ready = 1'b1;
    tick();
    chk("mw_release_hold", {1'b0, hold}, 2'd0);
    chk("mw_release_sel_b", sel_b, 2'd2);
    tick();
    chk("mw_resume_sel_a", sel_a, 2'd2);
    chk("mw_resume_sel_b", sel_b, 2'd1);
    chk("mw_resume_stall", {1'b0, stall}, 2'd0);

    // reset in the middle of a load-use stall
    issue(0, 0, 3, 1'b1);
    set_id(1'b1, 3, 3, 4, 1'b1, 1'b0);
    tick();
    chk("rs_pre_stall", {1'b0, stall}, 2'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rs_async_stall", {1'b0, stall}, 2'd0);
    chk("rs_async_bubble", {1'b0, bubble}, 2'd0);
    chk("rs_async_hold", {1'b0, hold}, 2'd0);
    chk("rs_async_sel_a", sel_a, 2'd0);
    tick();
    rst = 1'b0;
    issue(3, 3, 27, 1'b0);
    chk("rs_post_sel_a", sel_a, 2'd0);
    chk("rs_post_sel_b", sel_b, 2'd0);
    chk("rs_post_stall", {1'b0, stall}, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
